// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite slave memory target: parametrised width/depth/base, byte strobes,
// SLVERR on out-of-range accesses and per-channel configurable ready/response delays.

module axi4_lite_slave_mem_chan #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   cfg_wait,
    input  logic         valid,
    input  logic         done,
    input  logic [W-1:0] data_i,
    output logic         ready,
    output logic         full,
    output logic [W-1:0] data_q
);
    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_RDY  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         load_q, load_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic [W-1:0] data_d;

    // load_q marks the first wait cycle, where cfg_wait is sampled; that keeps
    // reset release and post-response reload on the same wait+1 edge latency.
    always_comb begin
        state_d = state_q;
        load_d  = load_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_WAIT: begin
                if (load_q) begin
                    if (cfg_wait == 8'd0) begin
                        state_d = S_RDY;
                    end else begin
                        cnt_d  = cfg_wait - 8'd1;
                        load_d = 1'b0;
                    end
                end else if (cnt_q == 8'd0) begin
                    state_d = S_RDY;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RDY: begin
                if (valid) begin
                    state_d = S_FULL;
                    data_d  = data_i;
                end
            end
            S_FULL: begin
                if (done) begin
                    state_d = S_WAIT;
                    load_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_WAIT;
                load_d  = 1'b1;
            end
        endcase
        ready_d = (state_d == S_RDY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            load_q  <= 1'b1;
            cnt_q   <= 8'd0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

    assign ready = ready_q;
    assign full  = (state_q == S_FULL);
endmodule

module axi4_lite_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [2:0]                s_arprot,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    input  logic [7:0]                cfg_aw_wait,
    input  logic [7:0]                cfg_w_wait,
    input  logic [7:0]                cfg_b_wait,
    input  logic [7:0]                cfg_ar_wait,
    input  logic [7:0]                cfg_r_wait
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH * BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

    logic                    aw_full, w_full, ar_full, b_done, r_done;
    logic [ADDR_WIDTH-1:0]   awaddr_buf, araddr_buf;
    logic [BYTES-1:0]        wstrb_buf;
    logic [DATA_WIDTH-1:0]   wdata_buf;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic unused_prot;
    assign unused_prot = ^{s_awprot, s_arprot};

    axi4_lite_slave_mem_chan #(.W(ADDR_WIDTH)) u_aw (
        .clk(aclk), .rst_n(aresetn), .cfg_wait(cfg_aw_wait), .valid(s_awvalid),
        .done(b_done), .data_i(s_awaddr), .ready(s_awready), .full(aw_full), .data_q(awaddr_buf)
    );
    axi4_lite_slave_mem_chan #(.W(BYTES + DATA_WIDTH)) u_w (
        .clk(aclk), .rst_n(aresetn), .cfg_wait(cfg_w_wait), .valid(s_wvalid),
        .done(b_done), .data_i({s_wstrb, s_wdata}), .ready(s_wready), .full(w_full),
        .data_q({wstrb_buf, wdata_buf})
    );
    axi4_lite_slave_mem_chan #(.W(ADDR_WIDTH)) u_ar (
        .clk(aclk), .rst_n(aresetn), .cfg_wait(cfg_ar_wait), .valid(s_arvalid),
        .done(r_done), .data_i(s_araddr), .ready(s_arready), .full(ar_full), .data_q(araddr_buf)
    );

    // Addresses below BASE_ADDR wrap to a large offset and fail the span test.
    logic [ADDR_WIDTH-1:0] wr_off, rd_off;
    logic                  wr_in, rd_in;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    assign wr_off = awaddr_buf - BASE_ADDR;
    assign rd_off = araddr_buf - BASE_ADDR;
    assign wr_in  = {1'b0, wr_off} < SPAN;
    assign rd_in  = {1'b0, rd_off} < SPAN;
    assign wr_idx = wr_off[OFF_W +: IDX_W];
    assign rd_idx = rd_off[OFF_W +: IDX_W];

    logic [1:0]            bst_q, bst_d, rst_q, rst_d, bresp_q, bresp_d, rresp_q, rresp_d;
    logic [7:0]            bcnt_q, bcnt_d, rcnt_q, rcnt_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d, b_commit, r_commit;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        bst_d    = bst_q;
        bcnt_d   = bcnt_q;
        bresp_d  = bresp_q;
        b_commit = 1'b0;
        b_done   = 1'b0;
        case (bst_q)
            S_IDLE: begin
                if (aw_full && w_full) begin
                    if (cfg_b_wait == 8'd0) begin
                        bst_d    = S_RESP;
                        b_commit = 1'b1;
                    end else begin
                        bst_d  = S_DELAY;
                        bcnt_d = cfg_b_wait - 8'd1;
                    end
                end
            end
            S_DELAY: begin
                if (bcnt_q == 8'd0) begin
                    bst_d    = S_RESP;
                    b_commit = 1'b1;
                end else begin
                    bcnt_d = bcnt_q - 8'd1;
                end
            end
            S_RESP: begin
                if (s_bready) begin
                    bst_d  = S_IDLE;
                    b_done = 1'b1;
                end
            end
            default: bst_d = S_IDLE;
        endcase
        if (b_commit) bresp_d = wr_in ? OKAY : SLVERR;
        bvalid_d = (bst_d == S_RESP);
    end

    always_comb begin
        rst_d    = rst_q;
        rcnt_d   = rcnt_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        r_commit = 1'b0;
        r_done   = 1'b0;
        case (rst_q)
            S_IDLE: begin
                if (ar_full) begin
                    if (cfg_r_wait == 8'd0) begin
                        rst_d    = S_RESP;
                        r_commit = 1'b1;
                    end else begin
                        rst_d  = S_DELAY;
                        rcnt_d = cfg_r_wait - 8'd1;
                    end
                end
            end
            S_DELAY: begin
                if (rcnt_q == 8'd0) begin
                    rst_d    = S_RESP;
                    r_commit = 1'b1;
                end else begin
                    rcnt_d = rcnt_q - 8'd1;
                end
            end
            S_RESP: begin
                if (s_rready) begin
                    rst_d  = S_IDLE;
                    r_done = 1'b1;
                end
            end
            default: rst_d = S_IDLE;
        endcase
        // Sampled before this edge's memory write lands, so a same-word collision reads old data.
        if (r_commit) begin
            rresp_d = rd_in ? OKAY : SLVERR;
            rdata_d = rd_in ? mem_q[rd_idx] : '0;
        end
        rvalid_d = (rst_d == S_RESP);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bst_q    <= S_IDLE;
            bcnt_q   <= 8'd0;
            bresp_q  <= OKAY;
            bvalid_q <= 1'b0;
            rst_q    <= S_IDLE;
            rcnt_q   <= 8'd0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            bst_q    <= bst_d;
            bcnt_q   <= bcnt_d;
            bresp_q  <= bresp_d;
            bvalid_q <= bvalid_d;
            rst_q    <= rst_d;
            rcnt_q   <= rcnt_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (b_commit && wr_in) begin
            for (int b = 0; b < BYTES; b++)
                if (wstrb_buf[b]) mem_q[wr_idx][b*8 +: 8] <= wdata_buf[b*8 +: 8];
        end
    end

    assign s_bvalid = bvalid_q;
    assign s_bresp  = bresp_q;
    assign s_rvalid = rvalid_q;
    assign s_rresp  = rresp_q;
    assign s_rdata  = rdata_q;
endmodule

// File: tb/tb_axi4_lite_slave_mem.sv
// Scoreboard bench for axi4_lite_slave_mem: expected B/R responses are queued at
// issue time from a byte-lane memory model and checked when the response handshakes.

module tb_axi4_lite_slave_mem;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam logic [AW-1:0] BASE = 32'h0;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
    logic [2:0]    s_awprot = '0, s_arprot = '0;
    logic          s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 1, s_rready = 1;
    logic [DW-1:0] s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]    s_bresp, s_rresp;
    logic [DW-1:0] s_rdata;
    logic [7:0]    cfg_aw_wait = 0, cfg_w_wait = 0, cfg_b_wait = 0, cfg_ar_wait = 0, cfg_r_wait = 0;

    int checks = 0;
    int errors = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] model [DEPTH];

    axi4_lite_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .cfg_aw_wait(cfg_aw_wait), .cfg_w_wait(cfg_w_wait), .cfg_b_wait(cfg_b_wait),
        .cfg_ar_wait(cfg_ar_wait), .cfg_r_wait(cfg_r_wait)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic in_rng(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE;
        return off < AW'(DEPTH * 4);
    endfunction

    function automatic int widx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE;
        return int'(off >> 2) % DEPTH;
    endfunction

    // Response monitor: a handshake seen valid&ready at negedge completes on the next posedge.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (s_bvalid && s_bready) begin
                chk("b_expected", 32'(bq.size() > 0), 1);
                if (bq.size() > 0) chk("bresp", s_bresp, bq.pop_front());
            end
            if (s_rvalid && s_rready) begin
                chk("r_expected", 32'(rq.size() > 0), 1);
                if (rq.size() > 0) chk("rresp_rdata", {s_rresp, s_rdata}, rq.pop_front());
            end
        end
    end

    task automatic wr_req(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] st);
        bit awd = 0, wd = 0, aw_hs, w_hs;
        int n = 0;
        s_awaddr = a; s_wdata = d; s_wstrb = st;
        s_awvalid = 1; s_wvalid = 1;
        if (in_rng(a)) begin
            for (int b = 0; b < 4; b++) if (st[b]) model[widx(a)][b*8 +: 8] = d[b*8 +: 8];
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b10);
        end
        while (!(awd && wd) && n < 100) begin
            @(negedge aclk);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge aclk); #1;
            if (aw_hs) begin s_awvalid = 0; awd = 1; end
            if (w_hs)  begin s_wvalid = 0;  wd = 1;  end
            n++;
        end
        if (n >= 100) chk("wr_hs_timeout", n, 0);
    endtask

    task automatic rd_req(input logic [AW-1:0] a);
        bit hs = 0;
        int n = 0;
        s_araddr = a; s_arvalid = 1;
        rq.push_back(in_rng(a) ? {2'b00, model[widx(a)]} : {2'b10, 32'h0});
        while (!hs && n < 100) begin
            @(negedge aclk);
            hs = s_arvalid && s_arready;
            @(posedge aclk); #1;
            if (hs) s_arvalid = 0;
            n++;
        end
        if (n >= 100) chk("rd_hs_timeout", n, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 200) begin
            @(posedge aclk);
            n++;
        end
        #1;
        if (n >= 200) chk("resp_timeout", n, 0);
    endtask

    task automatic do_reset();
        aresetn = 0;
        bq.delete(); rq.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        @(negedge aclk);
        chk("rst_ready", {s_awready, s_wready, s_arready}, 0);
        chk("rst_valid", {s_bvalid, s_rvalid}, 0);
        chk("rst_resp", {s_bresp, s_rresp}, 0);
        chk("rst_rdata", s_rdata, 0);
        @(posedge aclk); #1;
        aresetn = 1;
    endtask

    // After release: aw/w ready one edge later (their waits are 0), ar after cfg_ar_wait+1.
    task automatic release_check(input int exp_ar);
        int n = 0;
        while (!s_arready && n < 20) begin
            @(posedge aclk);
            n++;
            @(negedge aclk);
            if (n == 1) begin
                chk("rel_awwready", {s_awready, s_wready}, 2'b11);
                chk("rel_bvrv", {s_bvalid, s_rvalid}, 2'b00);
            end
        end
        chk("rel_arready_edges", n, exp_ar);
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        @(posedge aclk); #1;
        do_reset();
        release_check(1);

        wr_req(32'h10, 32'hDEADBEEF, 4'hF); drain();
        rd_req(32'h10); drain();
        wr_req(32'h10, 32'h11223344, 4'h5); drain();
        rd_req(32'h10); drain();
        chk("merge_model", model[4], 32'hDE22BE44);

        // W leads AW by 3 cycles; B must appear cfg_b_wait+1 edges after the AW handshake.
        cfg_b_wait = 8'd4;
        s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF; s_wvalid = 1;
        @(negedge aclk);
        chk("w_first_ready", s_wready, 1);
        @(posedge aclk); #1; s_wvalid = 0;
        repeat (2) begin @(posedge aclk); #1; end
        s_awaddr = 32'h20; s_awvalid = 1;
        model[8] = 32'hCAFEF00D; bq.push_back(2'b00);
        @(negedge aclk);
        chk("aw_late_ready", s_awready, 1);
        chk("b_before_aw", s_bvalid, 0);
        @(posedge aclk); #1; s_awvalid = 0;
        n = 0;
        do begin
            @(posedge aclk); n++;
            @(negedge aclk);
        end while (!s_bvalid && n < 20);
        chk("b_delay_edges", n, 5);
        drain();
        cfg_b_wait = 8'd0;
        rd_req(32'h20); drain();

        wr_req(32'h0, 32'hA5A50001, 4'hF); drain();
        wr_req(32'h40, 32'h12345678, 4'hF); drain();
        rd_req(32'h0); drain();
        rd_req(32'h40); drain();
        wr_req(32'h10, 32'hFFFFFFFF, 4'h0); drain();
        rd_req(32'h13); drain();

        // Stall both responses, then reset while they are pending.
        cfg_ar_wait = 8'd2;
        s_bready = 0; s_rready = 0;
        wr_req(32'h30, 32'h55AA55AA, 4'hF);
        rd_req(32'h10);
        n = 0;
        do begin @(negedge aclk); n++; end while (!(s_bvalid && s_rvalid) && n < 20);
        chk("stall_reached", 32'(s_bvalid && s_rvalid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            chk("stall_b", {s_bvalid, s_bresp}, {1'b1, bq[0]});
            chk("stall_r", {s_rvalid, s_rresp, s_rdata}, {1'b1, rq[0]});
            chk("stall_ar", s_arready, 0);
        end
        @(posedge aclk); #1;
        do_reset();
        s_bready = 1; s_rready = 1;
        release_check(3);
        rd_req(32'h30); drain();
        rd_req(32'h10); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
